// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, register index type and packed-port field extractor for regfile_mp
package rf_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int FW = 1024;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
  function automatic logic [63:0] port_field(input logic [FW-1:0] v, input int k, input int w);
    return 64'(v >> (k * w)) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: per-register write resolution across NWR ports (highest index wins, x0 dropped); in wr_en/wr_addr/wr_data/wr_clr, out we/wd/wc per register
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR*AW-1:0]          wr_addr,
  input  logic [NWR*XLEN-1:0]        wr_data,
  input  logic [NWR-1:0]             wr_clr,
  output logic [NREGS-1:0]           we,
  output logic [NREGS-1:0][XLEN-1:0] wd,
  output logic [NREGS-1:0]           wc
);
  logic [AW-1:0] a;
  always_comb begin
    we = '0;
    wd = '0;
    wc = '0;
    a = '0;
    for (int p = 0; p < NWR; p++) begin
      a = wr_addr[p*AW +: AW];
      if (wr_en[p] && a != '0) begin
        we[a] = 1'b1;
        wd[a] = wr_data[p*XLEN +: XLEN];
        wc[a] = wr_clr[p];
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with prioritized writes, optional write-to-read bypass and busy scoreboard; ports clk/rst_n, rd_addr->rd_data/rd_busy, wr_en/wr_addr/wr_data/wr_clr, iss_en/iss_addr, busy_vec
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NWR-1:0]       wr_clr,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [NREGS-1:0]     busy_vec
);
  logic [NREGS-1:0] we, wc;
  logic [NREGS-1:0][XLEN-1:0] wd, regs;
  logic [AW-1:0] ra;
  rf_wr_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR)) u_arb (
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_clr(wr_clr),
    .we(we),
    .wd(wd),
    .wc(wc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs <= '0;
      busy_vec <= '0;
    end else
      for (int r = 1; r < NREGS; r++) begin
        if (we[r]) regs[r] <= wd[r];
        busy_vec[r] <= (iss_en && iss_addr == AW'(r)) || (busy_vec[r] && !(we[r] && wc[r]));
      end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = AW'(port_field(FW'(rd_addr), k, AW));
      rd_data[k*XLEN +: XLEN] = !rst_n ? '0 : (BYPASS != 0 && we[ra]) ? wd[ra] : regs[ra];
      rd_busy[k] = rst_n && busy_vec[ra] && !(BYPASS != 0 && we[ra] && wc[ra]);
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus randomized check of regfile_mp (BYPASS=1 and BYPASS=0) against an array-based reference model
module tb_regfile_mp;
  import rf_pkg::*;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0] rd_busy_b, rd_busy_n;
  logic [NWR-1:0] wr_en = '0, wr_clr = '0;
  logic [NWR*AW-1:0] wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic iss_en = 1'b0;
  reg_idx_t iss_addr = '0;
  logic [NREGS-1:0] busy_vec_b, busy_vec_n;
  logic [XLEN-1:0] m_regs [NREGS];
  logic m_busy [NREGS];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  regfile_mp #(.BYPASS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_b)
  );
  regfile_mp #(.BYPASS(0)) u_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_n)
  );
  function automatic int winner(input int a);
    int w = -1;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a && a != 0) w = p;
    return w;
  endfunction
  function automatic logic [XLEN-1:0] exp_data(input bit b, input int a);
    int w = winner(a);
    if (!rst_n || a == 0) return '0;
    if (b && w >= 0) return wr_data[w*XLEN +: XLEN];
    return m_regs[a];
  endfunction
  function automatic logic exp_busy(input bit b, input int a);
    int w = winner(a);
    if (!rst_n || a == 0) return 1'b0;
    if (b && w >= 0 && wr_clr[w]) return 1'b0;
    return m_busy[a];
  endfunction
  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    logic [NREGS-1:0] bv = '0;
    for (int r = 0; r < NREGS; r++) bv[r] = rst_n && m_busy[r];
    chk({tag, ":busy_vec_b"}, busy_vec_b, bv);
    chk({tag, ":busy_vec_n"}, busy_vec_n, bv);
    for (int k = 0; k < NRD; k++) begin
      int a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("%s:rd_data_b%0d", tag, k), rd_data_b[k*XLEN +: XLEN], exp_data(1'b1, a));
      chk($sformatf("%s:rd_data_n%0d", tag, k), rd_data_n[k*XLEN +: XLEN], exp_data(1'b0, a));
      chk($sformatf("%s:rd_busy_b%0d", tag, k), XLEN'(rd_busy_b[k]), XLEN'(exp_busy(1'b1, a)));
      chk($sformatf("%s:rd_busy_n%0d", tag, k), XLEN'(rd_busy_n[k]), XLEN'(exp_busy(1'b0, a)));
    end
  endtask
  task automatic tick();
    logic [XLEN-1:0] nr [NREGS];
    logic nb [NREGS];
    for (int r = 0; r < NREGS; r++) begin
      int w = winner(r);
      nr[r] = w >= 0 ? wr_data[w*XLEN +: XLEN] : m_regs[r];
      nb[r] = r != 0 && ((iss_en && int'(iss_addr) == r) || (m_busy[r] && !(w >= 0 && wr_clr[w])));
    end
    @(posedge clk);
    if (rst_n) begin
      m_regs = nr;
      m_busy = nb;
    end
    #1;
  endtask
  task automatic reset_pulse();
    rst_n = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    #1;
  endtask
  task automatic idle();
    wr_en = '0;
    wr_clr = '0;
    iss_en = 1'b0;
  endtask
  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic c);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
    wr_clr[p] = c;
  endtask
  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask
  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1;
    iss_addr = a;
  endtask
  initial begin
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    #3;
    set_wr(0, 5'd4, 32'h44, 1'b0);
    set_rd(0, 5'd4);
    #1 check_all("reset_hold");
    @(negedge clk) rst_n = 1'b1;
    #1 check_all("release");
    issue(5'd4);
    tick();
    idle();
    #1 check_all("pre_reset");
    #2 reset_pulse();
    check_all("async_reset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    set_wr(0, 5'd0, 32'hDEADBEEF, 1'b0);
    set_rd(0, 5'd0);
    issue(5'd0);
    #1 check_all("x0_write");
    tick();
    idle();
    #1 check_all("x0_read");
    set_wr(0, 5'd5, 32'h12345678, 1'b0);
    tick();
    idle();
    set_wr(1, 5'd6, 32'hCAFEF00D, 1'b0);
    tick();
    idle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    #1 check_all("basic");
    set_wr(0, 5'd7, 32'h1111, 1'b0);
    set_wr(1, 5'd7, 32'h2222, 1'b0);
    tick();
    idle();
    set_rd(0, 5'd7);
    #1 check_all("conflict");
    set_wr(0, 5'd9, 32'hABCD, 1'b0);
    set_rd(0, 5'd9);
    #1 check_all("bypass_same");
    tick();
    idle();
    #1 check_all("bypass_next");
    issue(5'd10);
    set_rd(0, 5'd10);
    tick();
    idle();
    #1 check_all("sb_issue");
    set_wr(0, 5'd10, 32'h1, 1'b0);
    #1 check_all("sb_noclr_same");
    tick();
    idle();
    #1 check_all("sb_noclr_next");
    set_wr(1, 5'd10, 32'h2, 1'b1);
    #1 check_all("sb_clr_same");
    tick();
    idle();
    #1 check_all("sb_clr_next");
    issue(5'd10);
    set_wr(0, 5'd10, 32'h3, 1'b1);
    #1 check_all("sb_iss_clr_same");
    tick();
    idle();
    #1 check_all("sb_iss_clr_next");
    set_wr(0, 5'd3, 32'h55, 1'b0);
    issue(5'd3);
    tick();
    idle();
    set_rd(0, 5'd3);
    #1 check_all("x3_busy");
    #2 reset_pulse();
    check_all("x3_reset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    set_wr(0, 5'd3, 32'h77, 1'b0);
    tick();
    idle();
    #1 check_all("x3_after");
    repeat (300) begin
      idle();
      for (int p = 0; p < NWR; p++) begin
        wr_en[p] = 1'($urandom_range(0, 1));
        wr_addr[p*AW +: AW] = $urandom_range(0, 2) == 0 ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
        wr_data[p*XLEN +: XLEN] = $urandom;
        wr_clr[p] = 1'($urandom_range(0, 1));
      end
      iss_en = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, 15));
      for (int k = 0; k < NRD; k++)
        rd_addr[k*AW +: AW] = $urandom_range(0, 1) == 0 ? wr_addr[($urandom_range(0, NWR - 1))*AW +: AW] : AW'($urandom_range(0, 31));
      #1 check_all("rnd");
      if ($urandom_range(0, 39) == 0) begin
        #1 reset_pulse();
        check_all("rnd_reset");
        @(negedge clk) rst_n = 1'b1;
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
